if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
// - Instruction-fetch stage directly upstream of the IF/ID stage register.
// - Owns the PC, drives the instruction-memory (I-cache) read handshake and presents
//   {pc_o, ir_o, valid_o} to IF/ID.
// - Handles hazard-unit stalls and EX-stage redirects, including redirects that land
//   while a memory read is outstanding.
// PARAMETERS
// - RESET_PC   32'h0000_0060  PC loaded on reset
// - NOP_INSN   32'h0000_0013  ir_o value whenever valid_o=0 (addi x0,x0,0)
// PORTS
// - clk            in   1   clock; all state updates on posedge
// - rst            in   1   synchronous, active-high reset
// - stall_i        in   1   downstream stall; IF/ID load = ~stall_i
// - redirect_i     in   1   branch/jump taken; overrides sequential PC
// - redirect_pc_i  in   32  redirect target
// - imem_read      out  1   read request; held high until imem_resp
// - imem_address   out  32  word-aligned fetch address
// - imem_rdata     in   32  instruction word, valid with imem_resp
// - imem_resp      in   1   one-cycle read completion strobe
// - pc_o           out  32  PC of presented instruction
// - ir_o           out  32  presented instruction (NOP_INSN when invalid)
// - valid_o        out  1   pc_o/ir_o hold a live instruction this cycle
// BEHAVIOUR
// - Reset (rst=1): pc_q=RESET_PC, state=FETCH, tgt_q=0, buf cleared; imem_read=0,
//   valid_o=0, ir_o=NOP_INSN, pc_o=RESET_PC. The I-cache shares rst, so no response is
//   in flight after reset.
// - Reset mid-operation discards every outstanding request or buffered word.
// - imem_address = pc_q in every state. Redirect targets are stored with [1:0] forced
//   to 2'b00.
// - FETCH: imem_read=1; valid_o=imem_resp & ~redirect_i; ir_o=imem_rdata when valid.
//   Transitions, in priority order:
//   - resp & redirect: pc_q<=target; stay FETCH; returned word is dropped.
//   - redirect & ~resp: tgt_q<=target; go to DROP.
//   - resp & ~stall: pc_q<=pc_q+4; stay FETCH.
//   - resp & stall: go to HOLD if the feature is enabled, else REISSUE.
// - DROP: imem_read=1 with the old pc_q (the request cannot be withdrawn); valid_o=0.
//   - Another redirect overwrites tgt_q.
//   - On resp: data is discarded, pc_q<=tgt_q (or the new redirect target if one
//     arrives that cycle); go to FETCH.
// - REISSUE: imem_read=0, valid_o=0, one cycle.
//   - redirect: pc_q<=target.
//   - Next state is FETCH of pc_q.
// - HOLD: imem_read=0, valid_o=~redirect_i, ir_o=buf_q.
//   - redirect: pc_q<=target, go to FETCH.
//   - ~stall: pc_q<=pc_q+4, go to FETCH.
//   - else: stay in HOLD.
// - Handoff: an instruction is consumed only in a cycle with valid_o=1 and stall_i=0.
//   Each PC is consumed at most once. Latency is 1 cycle plus cache latency.
// - PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0.
// - Simultaneous redirect_i and stall_i: redirect wins; stall only suppresses
//   consumption.
// CONFIGURATION
// - IF_SKID_BUF_EN defined: a 32-bit skid register buf_q captures imem_rdata on
//   resp & stall & ~redirect.
//   - The stage enters HOLD and presents buf_q with no refetch.
//   - A stall costs 0 extra memory reads.
// - IF_SKID_BUF_EN undefined: HOLD and buf_q are not built.
//   - resp & stall goes to REISSUE and the same PC is refetched.
//   - Each stalled delivery costs one extra read plus one idle cycle.
// TESTING
// - Reset then 1-cycle-latency memory, no stall: imem_address sequence 0x60,0x64,0x68;
//   valid_o=1 on each resp; pc_o matches.
// - Redirect to 0x1003 in a non-resp FETCH cycle with 3-cycle memory: read held at the
//   old PC until resp; that word is dropped (valid_o=0); next address=0x1000.
// - Redirect coincident with resp: valid_o=0 that cycle; next imem_address=target;
//   no PC+4 fetch occurs.
// - stall_i=1 for 3 cycles across a resp of 0x00A00093 at PC 0x64.
//   - With IF_SKID_BUF_EN: ir_o holds 0x00A00093 with valid_o=1; after release,
//     pc_q=0x68 and exactly one read was issued for 0x64.
//   - Without it: after release, 0x64 is reread once, then consumed.
// - Assert rst during DROP: next cycle pc_o=0x60, valid_o=0, imem_read=0; first
//   post-reset fetch address=0x60.
// - Redirect to 0xFFFF_FFFC, no stall: next fetch address=0x0000_0000 (wrap).

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the I-cache read handshake and presents
// {pc_o, ir_o, valid_o} to IF/ID. Optional skid buffer enabled by IF_SKID_BUF_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o,
  output logic        valid_o,
  output logic [1:0]  dbg_state_o
);

  // Memory handshake: imem_read stays high with a stable imem_address until the
  // one-cycle imem_resp strobe; the request completes in that strobe cycle, and a
  // request that has been raised is never withdrawn (DROP waits it out).
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DROP    = 2'd1,
    S_REISSUE = 2'd2
`ifdef IF_SKID_BUF_EN
    ,
    S_HOLD    = 2'd3
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_tgt;
  logic [31:0] w_tgt_next;
  logic [31:0] w_redirect_tgt;
  logic [31:0] w_pc_inc;
  logic        w_read;
  logic        w_valid;
  logic        w_use_buf;
  logic        w_buf_load;

  assign w_redirect_tgt = redirect_pc_i & ~32'h0000_0003;
  assign w_pc_inc       = r_pc + 32'd4;

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_tgt_next   = r_tgt;
    w_read       = 1'b0;
    w_valid      = 1'b0;
    w_use_buf    = 1'b0;
    w_buf_load   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_read  = 1'b1;
        w_valid = imem_resp & ~redirect_i;
        if (imem_resp && redirect_i) begin
          w_pc_next = w_redirect_tgt;
        end else if (redirect_i) begin
          w_tgt_next   = w_redirect_tgt;
          w_next_state = S_DROP;
        end else if (imem_resp && !stall_i) begin
          w_pc_next = w_pc_inc;
        end else if (imem_resp) begin
`ifdef IF_SKID_BUF_EN
          w_buf_load   = 1'b1;
          w_next_state = S_HOLD;
`else
          w_next_state = S_REISSUE;
`endif
        end
      end
      S_DROP: begin
        // Old request is still outstanding; its data is thrown away on arrival.
        w_read = 1'b1;
        if (redirect_i) begin
          w_tgt_next = w_redirect_tgt;
        end
        if (imem_resp) begin
          w_pc_next    = redirect_i ? w_redirect_tgt : r_tgt;
          w_next_state = S_FETCH;
        end
      end
      S_REISSUE: begin
        if (redirect_i) begin
          w_pc_next = w_redirect_tgt;
        end
        w_next_state = S_FETCH;
      end
`ifdef IF_SKID_BUF_EN
      S_HOLD: begin
        w_valid   = ~redirect_i;
        w_use_buf = 1'b1;
        if (redirect_i) begin
          w_pc_next    = w_redirect_tgt;
          w_next_state = S_FETCH;
        end else if (!stall_i) begin
          w_pc_next    = w_pc_inc;
          w_next_state = S_FETCH;
        end
      end
`endif
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      r_tgt   <= w_tgt_next;
    end
  end

`ifdef IF_SKID_BUF_EN
  logic [31:0] r_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
    end else if (w_buf_load) begin
      r_buf <= imem_rdata;
    end
  end

  assign ir_o = valid_o ? (w_use_buf ? r_buf : imem_rdata) : NOP_INSN;
`else
  assign ir_o = valid_o ? imem_rdata : NOP_INSN;
`endif

  // While rst is held the outputs show the reset view regardless of leftover state.
  assign imem_read    = ~rst & w_read;
  assign valid_o      = ~rst & w_valid;
  assign imem_address = r_pc;
  assign pc_o         = rst ? RESET_PC : r_pc;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a variable-latency instruction memory model.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] pc_o;
  logic [31:0] ir_o;
  logic        valid_o;
  logic [1:0]  dbg_state_o;

  int checks;
  int errors;
  int lat;

  logic [31:0] req_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ir[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .pc_o         (pc_o),
    .ir_o         (ir_o),
    .valid_o      (valid_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0064) return 32'h00A0_0093;
    return a ^ 32'hA5A5_0000;
  endfunction

  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;

  always @(posedge clk) begin
    if (rst) begin
      m_busy     <= 1'b0;
      m_cnt      <= 0;
      m_addr     <= '0;
      imem_resp  <= 1'b0;
      imem_rdata <= '0;
      req_log.delete();
    end else begin
      imem_resp <= 1'b0;
      if (m_busy) begin
        if (m_cnt <= 1) begin
          m_busy     <= 1'b0;
          imem_resp  <= 1'b1;
          imem_rdata <= mem_word(m_addr);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (imem_read && !imem_resp) begin
        req_log.push_back(imem_address);
        if (lat <= 1) begin
          imem_resp  <= 1'b1;
          imem_rdata <= mem_word(imem_address);
        end else begin
          m_busy <= 1'b1;
          m_addr <= imem_address;
          m_cnt  <= lat - 1;
        end
      end
    end
  end

  // ---------------- consumption monitor ----------------
  always @(posedge clk) begin
    if (rst) begin
      got_pc.delete();
      got_ir.delete();
    end else if (valid_o && !stall_i) begin
      got_pc.push_back(pc_o);
      got_ir.push_back(ir_o);
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      nxt();
      if (valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_resp(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      nxt();
      if (imem_resp === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n64;
    checks        = 0;
    errors        = 0;
    lat           = 1;
    rst           = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;

    // Reset view
    nxt(); #1;
    check("rst_read",  {31'd0, imem_read}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_ir",    ir_o, NOP);
    check("rst_pc",    pc_o, 32'h0000_0060);
    check("rst_state", {30'd0, dbg_state_o}, 32'd0);
    nxt();
    rst = 1'b0; #1;
    check("first_read", {31'd0, imem_read}, 32'd1);
    check("first_addr", imem_address, 32'h0000_0060);

    // Sequential fetch, 1-cycle memory
    wait_valid("seq0_wait", 8);
    check("seq0_pc", pc_o, 32'h0000_0060);
    check("seq0_ir", ir_o, 32'hA5A5_0060);
    wait_valid("seq1_wait", 8);
    check("seq1_pc", pc_o, 32'h0000_0064);
    check("seq1_ir", ir_o, 32'h00A0_0093);
    wait_valid("seq2_wait", 8);
    check("seq2_pc", pc_o, 32'h0000_0068);
    check("seq2_ir", ir_o, 32'hA5A5_0068);
    check("seq_nreq", 32'(req_log.size()), 32'd3);
    check("seq_req1", req_log[1], 32'h0000_0064);
    check("seq_req2", req_log[2], 32'h0000_0068);

    // Redirect in a non-resp FETCH cycle, 3-cycle memory
    lat = 3;
    nxt();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_1003; #1;
    check("rd_valid", {31'd0, valid_o}, 32'd0);
    check("rd_addr",  imem_address, 32'h0000_006C);
    nxt();
    redirect_i = 1'b0; #1;
    check("drop_state", {30'd0, dbg_state_o}, 32'd1);
    check("drop_read",  {31'd0, imem_read}, 32'd1);
    check("drop_addr",  imem_address, 32'h0000_006C);
    wait_resp("drop_resp_wait", 8);
    #1;
    check("drop_valid", {31'd0, valid_o}, 32'd0);
    check("drop_addr2", imem_address, 32'h0000_006C);
    nxt(); #1;
    check("post_drop_addr",  imem_address, 32'h0000_1000);
    check("post_drop_state", {30'd0, dbg_state_o}, 32'd0);
    wait_valid("tgt_wait", 10);
    check("tgt_pc",   pc_o, 32'h0000_1000);
    check("tgt_ir",   ir_o, 32'hA5A5_1000);
    check("tgt_nreq", 32'(req_log.size()), 32'd5);
    check("tgt_req",  req_log[4], 32'h0000_1000);
    check("tgt_ngot", 32'(got_pc.size()), 32'd3);

    // Redirect coincident with resp
    lat = 1;
    wait_resp("co_resp_wait", 8);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_2000; #1;
    check("co_valid", {31'd0, valid_o}, 32'd0);
    check("co_ir",    ir_o, NOP);
    nxt();
    redirect_i = 1'b0; #1;
    check("co_addr",  imem_address, 32'h0000_2000);
    check("co_ngot",  32'(got_pc.size()), 32'd4);
    check("co_gotpc", got_pc[3], 32'h0000_1000);
    wait_valid("co_tgt_wait", 8);
    check("co_tgt_pc", pc_o, 32'h0000_2000);
    check("co_nreq",   32'(req_log.size()), 32'd7);
    check("co_req5",   req_log[5], 32'h0000_1004);
    check("co_req6",   req_log[6], 32'h0000_2000);

    // Fresh reset, then 3-cycle stall across the resp for 0x64
    rst = 1'b1;
    nxt(); nxt();
    rst = 1'b0;
    wait_valid("st_first_wait", 8);
    check("st_first_pc", pc_o, 32'h0000_0060);
    wait_resp("st_resp_wait", 8);
    stall_i = 1'b1; #1;
    check("st_valid1", {31'd0, valid_o}, 32'd1);
    check("st_ir1",    ir_o, 32'h00A0_0093);
    check("st_pc1",    pc_o, 32'h0000_0064);
    nxt(); #1;
`ifdef IF_SKID_BUF_EN
    check("st_hold_state", {30'd0, dbg_state_o}, 32'd3);
    check("st_hold_read",  {31'd0, imem_read}, 32'd0);
    check("st_hold_valid", {31'd0, valid_o}, 32'd1);
    check("st_hold_ir",    ir_o, 32'h00A0_0093);
    nxt(); #1;
    check("st_hold_valid2", {31'd0, valid_o}, 32'd1);
    check("st_hold_ir2",    ir_o, 32'h00A0_0093);
    check("st_hold_pc2",    pc_o, 32'h0000_0064);
`else
    check("st_reiss_state", {30'd0, dbg_state_o}, 32'd2);
    check("st_reiss_read",  {31'd0, imem_read}, 32'd0);
    check("st_reiss_valid", {31'd0, valid_o}, 32'd0);
    nxt(); #1;
    check("st_refetch_read", {31'd0, imem_read}, 32'd1);
    check("st_refetch_addr", imem_address, 32'h0000_0064);
    check("st_refetch_valid", {31'd0, valid_o}, 32'd0);
`endif
    check("st_nocons", 32'(got_pc.size()), 32'd1);
    nxt();
    stall_i = 1'b0; #1;
    check("st_rel_valid", {31'd0, valid_o}, 32'd1);
    check("st_rel_ir",    ir_o, 32'h00A0_0093);
    check("st_rel_pc",    pc_o, 32'h0000_0064);
    nxt(); #1;
    check("st_next_addr", imem_address, 32'h0000_0068);
    check("st_ngot",      32'(got_pc.size()), 32'd2);
    check("st_gotpc",     got_pc[1], 32'h0000_0064);
    check("st_gotir",     got_ir[1], 32'h00A0_0093);
    n64 = 0;
    for (int i = 0; i < req_log.size(); i++) begin
      if (req_log[i] == 32'h0000_0064) n64++;
    end
`ifdef IF_SKID_BUF_EN
    check("st_reads64", 32'(n64), 32'd1);
`else
    check("st_reads64", 32'(n64), 32'd2);
`endif

    // Reset asserted while in DROP
    lat = 3;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_3000;
    nxt();
    redirect_i = 1'b0; #1;
    check("rdrop_state", {30'd0, dbg_state_o}, 32'd1);
    rst = 1'b1; #1;
    check("rdrop_rst_read", {31'd0, imem_read}, 32'd0);
    nxt(); #1;
    check("rdrop_pc",    pc_o, 32'h0000_0060);
    check("rdrop_valid", {31'd0, valid_o}, 32'd0);
    check("rdrop_read",  {31'd0, imem_read}, 32'd0);
    check("rdrop_state2", {30'd0, dbg_state_o}, 32'd0);
    rst = 1'b0; #1;
    check("rdrop_addr",  imem_address, 32'h0000_0060);
    check("rdrop_read2", {31'd0, imem_read}, 32'd1);
    wait_valid("rdrop_wait", 10);
    check("rdrop_vpc",  pc_o, 32'h0000_0060);
    check("rdrop_vir",  ir_o, 32'hA5A5_0060);
    check("rdrop_nreq", 32'(req_log.size()), 32'd1);

    // Redirect, overwritten in DROP by an unaligned target near the top; PC wraps
    lat = 1;
    nxt();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_4000;
    nxt();
    redirect_pc_i = 32'hFFFF_FFFD; #1;
    check("wr_drop_state", {30'd0, dbg_state_o}, 32'd1);
    check("wr_drop_valid", {31'd0, valid_o}, 32'd0);
    nxt();
    redirect_i = 1'b0; #1;
    check("wr_addr", imem_address, 32'hFFFF_FFFC);
    wait_valid("wr_wait", 8);
    check("wr_pc", pc_o, 32'hFFFF_FFFC);
    check("wr_ir", ir_o, 32'h5A5A_FFFC);
    nxt(); #1;
    check("wr_wrap_addr", imem_address, 32'h0000_0000);
    check("wr_wrap_read", {31'd0, imem_read}, 32'd1);
    check("wr_nreq",  32'(req_log.size()), 32'd3);
    check("wr_req2",  req_log[2], 32'hFFFF_FFFC);
    check("wr_ngot",  32'(got_pc.size()), 32'd2);
    check("wr_gotpc", got_pc[1], 32'hFFFF_FFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
